// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
// Op codes, FSM states and big-endian lane helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD    = 2'd1,
        S_RDATA = 2'd2,
        S_WR    = 2'd3
    } state_e;

    // Byte offset 0 lives in the top lane (bits [31:24]).
    function automatic logic [1:0] BYTE_LANE_BIG(
        input logic [1:0] off
    );
        return 2'd3 - off;
    endfunction

    function automatic logic op_is_store(input op_e op);
        return (op == OP_SW) || (op == OP_SH) ||
               (op == OP_SB);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane extraction, extension and store merge.
// Purely combinational, big-endian byte order.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  op_e         i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged,
    output logic        o_misalign
);

    logic [4:0]  w_bpos;
    logic [4:0]  w_hpos;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // A halfword's low byte sits at off|1.
    assign w_bpos = {BYTE_LANE_BIG(i_off), 3'b000};
    assign w_hpos = {BYTE_LANE_BIG({i_off[1], 1'b1}), 3'b000};
    assign w_byte = 8'(i_word >> w_bpos);
    assign w_half = 16'(i_word >> w_hpos);

    // Extend the selected lane for loads.
    always_comb begin
        o_load = '0;
        case (i_op)
            OP_LW:   o_load = i_word;
            OP_LH:   o_load = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_load = {16'b0, w_half};
            OP_LB:   o_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_load = {24'b0, w_byte};
            default: o_load = '0;
        endcase
    end

    // Replace the addressed lane of the old word.
    always_comb begin
        o_merged = i_word;
        case (i_op)
            OP_SW: o_merged = i_wdata;
            OP_SH: o_merged =
                (i_word & ~(32'h0000_FFFF << w_hpos)) |
                ({16'b0, i_wdata[15:0]} << w_hpos);
            OP_SB: o_merged =
                (i_word & ~(32'h0000_00FF << w_bpos)) |
                ({24'b0, i_wdata[7:0]} << w_bpos);
            default: o_merged = i_word;
        endcase
    end

    // Words need 4-byte, halfwords 2-byte alignment.
    always_comb begin
        o_misalign = 1'b0;
        case (i_op)
            OP_LW, OP_SW:
                o_misalign = (i_off != 2'b00);
            OP_LH, OP_LHU, OP_SH:
                o_misalign = i_off[0];
            default:
                o_misalign = 1'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer in front of a word-wide
// single-port memory with registered read.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int addresswidth = 32,
    parameter int width        = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_op,
    input  logic [addresswidth-1:0] req_addr,
    input  logic [width-1:0]        req_wdata,
    output logic                    resp_valid,
    output logic [width-1:0]        resp_rdata,
    output logic                    resp_err,
    output logic [addresswidth-1:0] mem_address,
    output logic                    mem_read_en,
    output logic                    mem_write_en,
    output logic [width-1:0]        mem_data_in,
    input  logic [width-1:0]        mem_data_out
);

    state_e                  r_state;
    state_e                  w_next;
    op_e                     r_op;
    logic [addresswidth-1:0] r_addr;
    logic [width-1:0]        r_wword;
    logic [width-1:0]        r_rdata;
    logic                    r_resp_valid;
    logic                    r_resp_err;

    op_e                     w_op;
    logic [1:0]              w_off;
    logic [width-1:0]        w_load;
    logic [width-1:0]        w_merged;
    logic                    w_misalign;
    logic                    w_accept;

    // In IDLE the checker sees the live request,
    // otherwise the latched one.
    assign w_op  = (r_state == S_IDLE) ?
                   op_e'(req_op) : r_op;
    assign w_off = (r_state == S_IDLE) ?
                   req_addr[1:0] : r_addr[1:0];

    assign w_accept = req_valid && req_ready;

    lsu_lane_align u_align (
        .i_op       (w_op),
        .i_off      (w_off),
        .i_word     (mem_data_out),
        .i_wdata    (r_wword),
        .o_load     (w_load),
        .o_merged   (w_merged),
        .o_misalign (w_misalign)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and memory strobes.
    always_comb begin
        w_next       = r_state;
        req_ready    = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !w_misalign) begin
                    w_next = (w_op == OP_SW) ?
                             S_WR : S_RD;
                end
            end
            S_RD: begin
                mem_read_en = 1'b1;
                w_next      = S_RDATA;
            end
            S_RDATA: begin
                w_next = op_is_store(r_op) ?
                         S_WR : S_IDLE;
            end
            S_WR: begin
                mem_write_en = 1'b1;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch, merge buffer and response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op         <= OP_LW;
            r_addr       <= '0;
            r_wword      <= '0;
            r_rdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= op_e'(req_op);
                        r_addr  <= req_addr;
                        r_wword <= req_wdata;
                        if (w_misalign) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_rdata      <= '0;
                        end
                    end
                end
                S_RDATA: begin
                    if (op_is_store(r_op)) begin
                        r_wword <= w_merged;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_rdata      <= w_load;
                    end
                end
                S_WR: begin
                    r_resp_valid <= 1'b1;
                    r_rdata      <= '0;
                end
                default: ;
            endcase
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_rdata;
    assign resp_err    = r_resp_err;
    assign mem_data_in = r_wword;
    assign mem_address =
        {2'b00, r_addr[addresswidth-1:2]};

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a word memory
// stand-in and a byte-level reference model.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    load_store_unit #(
        .addresswidth (32),
        .width        (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_address  (mem_address),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stand-in: 256 words, registered read.
    logic [31:0] dmem [0:255];
    logic [31:0] pre  [0:255];
    logic        load_mem = 1'b0;
    logic [31:0] r_q  = '0;
    logic        r_qv = 1'b0;
    int          n_rd = 0;
    int          n_wr = 0;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) dmem[i] <= pre[i];
        end else if (mem_write_en) begin
            dmem[mem_address[7:0]] <= mem_data_in;
        end
        if (mem_read_en) r_q <= dmem[mem_address[7:0]];
        r_qv <= mem_read_en;
        if (mem_read_en)  n_rd <= n_rd + 1;
        if (mem_write_en) n_wr <= n_wr + 1;
    end

    // Poison value whenever the read port is idle.
    assign mem_data_out = r_qv ? r_q : 32'hA5A5_5A5A;

    // Reference: flat big-endian byte array.
    logic [7:0] ref_b [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h",
                   tag, obs, exp);
        end
    endtask

    function automatic void model(
        input  logic [2:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        output logic [31:0] rd,
        output logic        err,
        output int          lat,
        output int          nrd,
        output int          nwr);
        int b;
        b   = int'(a[9:0]);
        rd  = '0;
        err = 1'b0;
        lat = 3;
        nrd = 0;
        nwr = 0;
        if (((op == 0 || op == 5) && a[1:0] != 0) ||
            ((op == 1 || op == 2 || op == 6) && a[0])) begin
            err = 1'b1;
            lat = 1;
            return;
        end
        case (op)
            0: rd = {ref_b[b], ref_b[b+1],
                     ref_b[b+2], ref_b[b+3]};
            1: rd = {{16{ref_b[b][7]}},
                     ref_b[b], ref_b[b+1]};
            2: rd = {16'b0, ref_b[b], ref_b[b+1]};
            3: rd = {{24{ref_b[b][7]}}, ref_b[b]};
            4: rd = {24'b0, ref_b[b]};
            5: begin
                ref_b[b]   = wd[31:24];
                ref_b[b+1] = wd[23:16];
                ref_b[b+2] = wd[15:8];
                ref_b[b+3] = wd[7:0];
            end
            6: begin
                ref_b[b]   = wd[15:8];
                ref_b[b+1] = wd[7:0];
            end
            default: ref_b[b] = wd[7:0];
        endcase
        if (op < 5) begin
            nrd = 1;
        end else if (op == 5) begin
            lat = 2;
            nwr = 1;
        end else begin
            lat = 4;
            nrd = 1;
            nwr = 1;
        end
    endfunction

    // Issue one request starting at a negedge and
    // return at the negedge of its response cycle.
    task automatic do_op(input logic [2:0]  op,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         input bit          hold,
                         output logic [31:0] got_rd);
        logic [31:0] rd_exp;
        logic        err_exp;
        int          lat, nrd, nwr, rd0, wr0, cyc;
        bit          got;
        model(op, a, wd, rd_exp, err_exp, lat, nrd, nwr);
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        rd0 = n_rd;
        wr0 = n_wr;
        @(posedge clk);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 10) begin
            @(negedge clk);
            cyc++;
            req_op    = 3'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            chk("rd_wr_excl",
                32'(mem_read_en && mem_write_en), 32'd0);
            if (resp_valid) got = 1'b1;
            else chk("ready_busy", 32'(req_ready), 32'd0);
            req_valid = hold && !req_ready;
        end
        got_rd = resp_rdata;
        chk("latency", 32'(got ? cyc : 99), 32'(lat));
        chk("rdata",   resp_rdata, rd_exp);
        chk("err",     32'(resp_err), 32'(err_exp));
        chk("n_read",  32'(n_rd - rd0), 32'(nrd));
        chk("n_write", 32'(n_wr - wr0), 32'(nwr));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] r;
        int          w0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            if (i == 'h40) v = 32'h8899_AABB;
            pre[i] = v;
            ref_b[4*i]   = v[31:24];
            ref_b[4*i+1] = v[23:16];
            ref_b[4*i+2] = v[15:8];
            ref_b[4*i+3] = v[7:0];
        end
        load_mem = 1'b1;
        repeat (3) @(negedge clk);
        load_mem = 1'b0;
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err",   32'(resp_err), 32'd0);
        chk("rst_rden",  32'(mem_read_en), 32'd0);
        chk("rst_wren",  32'(mem_write_en), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);

        do_op(3'd3, 32'h100, 32'h0, 1'b0, r);
        chk("tp_lb",  r, 32'hFFFF_FF88);
        do_op(3'd4, 32'h103, 32'h0, 1'b0, r);
        chk("tp_lbu", r, 32'h0000_00BB);
        do_op(3'd1, 32'h102, 32'h0, 1'b0, r);
        chk("tp_lh",  r, 32'hFFFF_AABB);
        do_op(3'd2, 32'h100, 32'h0, 1'b0, r);
        chk("tp_lhu", r, 32'h0000_8899);

        do_op(3'd7, 32'h101, 32'h0000_0011, 1'b0, r);
        do_op(3'd0, 32'h100, 32'h0, 1'b0, r);
        chk("tp_sb",  r, 32'h8811_AABB);
        do_op(3'd6, 32'h102, 32'hFFFF_2233, 1'b0, r);
        do_op(3'd0, 32'h100, 32'h0, 1'b0, r);
        chk("tp_sh",  r, 32'h8811_2233);

        do_op(3'd0, 32'h102, 32'h0, 1'b0, r);
        do_op(3'd6, 32'h101, 32'h1234, 1'b0, r);

        do_op(3'd5, 32'h200, 32'hDEAD_BEEF, 1'b0, r);
        do_op(3'd0, 32'h200, 32'h0, 1'b0, r);
        chk("tp_b2b", r, 32'hDEAD_BEEF);

        do_op(3'd0, 32'h100, 32'h0, 1'b1, r);
        chk("tp_hold", r, 32'h8811_2233);

        // Reset during the RDATA cycle of an SB.
        req_valid = 1'b1;
        req_op    = 3'd7;
        req_addr  = 32'h100;
        req_wdata = 32'h77;
        w0 = n_wr;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_valid", 32'(resp_valid), 32'd0);
        chk("mrst_rdata", resp_rdata, 32'd0);
        chk("mrst_err",   32'(resp_err), 32'd0);
        chk("mrst_rden",  32'(mem_read_en), 32'd0);
        chk("mrst_wren",  32'(mem_write_en), 32'd0);
        chk("mrst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_nowr", 32'(n_wr - w0), 32'd0);
        do_op(3'd0, 32'h100, 32'h0, 1'b0, r);
        chk("mrst_word", r, 32'h8811_2233);

        for (int k = 0; k < 300; k++) begin
            do_op(3'($urandom),
                  32'($urandom_range(0, 1023)),
                  $urandom, bit'($urandom_range(0, 1)), r);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequences byte, halfword and word loads/stores from the execute stage onto the word-wide, single-port `datamemory`, which has a registered read and no byte enables. Sits directly upstream of `datamemory`. Generates word addresses and read/write enables, performs read-modify-write for `SB`/`SH`, and sign- or zero-extends load results. Memory is big-endian: byte offset 0 is bits [31:24].

## Interface
- `addresswidth`, 32: byte-address width of requests.
- `width`, 32: data width. Fixed at 32, since the lane logic assumes 4 bytes.
- `clk` in 1: single clock, posedge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`.
- `req_op` in 3: operation code. 0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU, 5=SW, 6=SH, 7=SB.
- `req_addr` in addresswidth: byte address.
- `req_wdata` in width: store data, right-justified for SB/SH.
- `resp_valid` out 1: one-cycle completion pulse for every accepted request.
- `resp_rdata` out width: load result, held until the next response; 0 for stores and errors.
- `resp_err` out 1: misaligned access, qualified by `resp_valid`.
- `mem_address` out addresswidth: word index, `{2'b00, addr[31:2]}`.
- `mem_read_en` out 1: memory read enable.
- `mem_write_en` out 1: memory write enable.
- `mem_data_in` out width: write data.
- `mem_data_out` in width: registered read data, valid the cycle after `mem_read_en`. Undriven (z) otherwise and must never be sampled then.

## Operation
- States: IDLE, RD, RDATA, WR.
- In IDLE, an accepted request latches op, addr and wdata.
- Misalignment check: LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]≠0.
  - No memory access is made; the FSM stays in IDLE.
  - `resp_valid=1`, `resp_err=1`, `resp_rdata=0` on the next cycle.
- Loads: IDLE→RD→RDATA→IDLE.
  - RD: `mem_read_en=1`.
  - RDATA: extract the lane from `mem_data_out` by addr[1:0].
    - LB/LH sign-extend; LBU/LHU zero-extend.
    - Register the result into `resp_rdata` with a `resp_valid` pulse.
- SW: IDLE→WR→IDLE.
  - WR: `mem_write_en=1`, `mem_data_in=wdata`, `resp_valid` pulse after the WR edge.
- SB/SH: IDLE→RD→RDATA→WR→IDLE.
  - RDATA registers the merged word: old word with the selected byte/halfword replaced by wdata[7:0] or wdata[15:0].
  - WR writes the merged word and pulses `resp_valid`.
- `mem_read_en` and `mem_write_en` are never high together, and both are 0 in IDLE.
- `mem_address` is driven from the latched addr in every non-IDLE state.

## Timing
- Reset values: state IDLE, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `mem_read_en=0`, `mem_write_en=0`. `req_ready=1` in the first cycle after reset.
- Latency from accept edge to `resp_valid` high (cycles):
  - Misaligned: 1.
  - SW: 2.
  - Loads: 3.
  - SB/SH: 4.
- `resp_valid` rises in the same cycle the FSM re-enters IDLE. A new request may be accepted at the end of that cycle, giving back-to-back throughput of 1/latency.
- Read-after-write: a load accepted in the `resp_valid` cycle of a store observes the stored value, because the write edge precedes the RD edge.
- Reset mid-operation: return to IDLE with no response. A write whose WR edge has not occurred is dropped; an RMW interrupted in RD or RDATA leaves memory unmodified.
- `req_op`, `req_addr` and `req_wdata` are sampled only on the accept edge; later changes are ignored.

## Structure
- Package `lsu_pkg`:
  - op encoding constants (`OP_LW` … `OP_SB`).
  - state encoding.
  - `BYTE_LANE_BIG` lane-index function.
- Sub-module `lsu_lane_align` (combinational):
  - Inputs: op, addr[1:0], memory word, store data.
  - Outputs: extended load value, merged store word, misalign flag.
- The FSM and registers stay in `load_store_unit`. `datamemory` is instantiated by the parent, not here.

## Test plan
- Preload word 0x100 = 0x8899AABB. LB at 0x100 → rdata 0xFFFFFF88; LBU at 0x103 → 0x000000BB; LH at 0x102 → 0xFFFFAABB; LHU at 0x100 → 0x00008899. Each with `resp_valid` exactly 3 cycles after accept.
- SB 0x11 at 0x101 then LW 0x100 → 0x8811AABB. SH 0x2233 at 0x102 then LW → 0x88112233. Write pulses exactly once per store.
- LW at 0x102 and SH at 0x101 → `resp_err=1` one cycle after accept, with zero `mem_read_en`/`mem_write_en` activity.
- Back-to-back: SW 0xDEADBEEF at 0x200 accepted in IDLE, then LW 0x200 accepted in the SW response cycle → 0xDEADBEEF. `req_ready` is low in all non-IDLE cycles.
- Assert `reset` during RDATA of an SB → no write, word unchanged, all outputs at reset values the next cycle, and `req_ready=1`.
- Hold `req_valid` high with changing `req_addr` while busy → only the value present on the accept edge is used.
